// File: rtl/dmem_lsu_if.sv
// Hart-side request/response and data-memory command bundle
// for the load/store unit.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_trap;
  logic [1:0]  rsp_cause;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic        dmem_ready;
  logic        dmem_valid;
  logic [31:0] dmem_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_funct3,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_trap, rsp_cause,
    output dmem_addr, dmem_ren, dmem_wen,
    output dmem_wdata, dmem_mask,
    input  dmem_ready, dmem_valid, dmem_rdata
  );

  modport master (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_funct3,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_trap, rsp_cause,
    input  dmem_addr, dmem_ren, dmem_wen,
    input  dmem_wdata, dmem_mask,
    output dmem_ready, dmem_valid, dmem_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one access at a time to a variable-latency
// data memory, with misalign, illegal-width and timeout traps.
module dmem_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic   i_clk,
  input  logic   i_rst,
  dmem_lsu_if.slave bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t        state_q, state_d;
  logic          wen_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] cnt_q;
  logic          pend_q, pend_d;
  logic [1:0]    tcause_q;
  logic [31:0]   rdata_q;
  logic          trap_q;
  logic [1:0]    cause_q;

  logic        accept;
  logic        illegal;
  logic        misal;
  logic        expire;
  logic        done;
  logic        tmo;
  logic        in_req;
  logic        rsp_load;
  logic [31:0] rsp_rdata_d;
  logic        rsp_trap_d;
  logic [1:0]  rsp_cause_d;

  function automatic logic [3:0] mask_of(
    input logic [1:0] sz, input logic [1:0] a);
    unique case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_of(
    input logic [1:0] sz, input logic [31:0] w);
    unique case (sz)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w, input logic [1:0] a,
    input logic [2:0] f);
    logic [31:0] s;
    s = w >> {a, 3'b000};
    unique case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_comb begin
    illegal = 1'b1;
    unique case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = bus.req_wen;
      default:                illegal = 1'b1;
    endcase
  end

  assign misal =
    (bus.req_funct3[1:0] == 2'b01 & bus.req_addr[0]) |
    (bus.req_funct3[1:0] == 2'b10 & |bus.req_addr[1:0]);

  assign accept = (state_q == IDLE) & ~pend_q &
                  bus.req_valid;
  assign expire = (TIMEOUT_CYCLES != 0) &&
                  (cnt_q == CNT_LAST);

  // A completion on the final counted cycle beats the timeout.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    done        = 1'b0;
    tmo         = 1'b0;
    rsp_load    = 1'b0;
    rsp_rdata_d = '0;
    rsp_trap_d  = 1'b0;
    rsp_cause_d = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d     = RESP;
          pend_d      = 1'b0;
          rsp_load    = 1'b1;
          rsp_trap_d  = 1'b1;
          rsp_cause_d = tcause_q;
        end else if (bus.req_valid) begin
          if (illegal | misal) pend_d = 1'b1;
          else                 state_d = REQ;
        end
      end
      REQ: begin
        if (bus.dmem_ready & bus.dmem_valid)
          done = 1'b1;
        else if (expire)
          tmo = 1'b1;
        else if (bus.dmem_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (bus.dmem_valid) done = 1'b1;
        else if (expire)    tmo = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d     = RESP;
      rsp_load    = 1'b1;
      rsp_rdata_d = wen_q ? 32'd0 :
        load_ext(bus.dmem_rdata, addr_q[1:0], f3_q);
    end
    if (tmo) begin
      state_d     = RESP;
      rsp_load    = 1'b1;
      rsp_trap_d  = 1'b1;
      rsp_cause_d = 2'b10;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      tcause_q <= 2'b00;
      cnt_q    <= '0;
      rdata_q  <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        wen_q    <= bus.req_wen;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        f3_q     <= bus.req_funct3;
        tcause_q <= illegal ? 2'b11 : 2'b01;
      end
      if (accept)
        cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT)
        cnt_q <= cnt_q + CW'(1);
      if (rsp_load) begin
        rdata_q <= rsp_rdata_d;
        trap_q  <= rsp_trap_d;
        cause_q <= rsp_cause_d;
      end
    end
  end

  assign in_req = (state_q == REQ);

  assign bus.req_ready  = (state_q == IDLE) & ~pend_q;
  assign bus.dmem_ren   = in_req & ~wen_q;
  assign bus.dmem_wen   = in_req & wen_q;
  assign bus.dmem_addr  = in_req ?
    {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.dmem_mask  = in_req ?
    mask_of(f3_q[1:0], addr_q[1:0]) : 4'd0;
  assign bus.dmem_wdata = in_req ?
    lane_of(f3_q[1:0], wdata_q) : 32'd0;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_trap   = trap_q;
  assign bus.rsp_cause  = cause_q;
endmodule
